// File: rtl/pixel_combinator_if.sv
// Pixel output stream of pixel_combinator: colour plus sof/eol markers with valid/ready.
interface pixel_combinator_if #(
  parameter int RBG_SIZE = 24
);
  logic [RBG_SIZE-1:0] pix_data_o;
  logic                pix_valid_o;
  logic                pix_ready_i;
  logic                sof_o;
  logic                eol_o;

  modport master (
    output pix_data_o, pix_valid_o, sof_o, eol_o,
    input  pix_ready_i
  );

  modport slave (
    input  pix_data_o, pix_valid_o, sof_o, eol_o,
    output pix_ready_i
  );
endinterface

// File: rtl/pixel_combinator.sv
// Raster-order combiner: broadcasts the next expected coordinate to the engine queues,
// captures the colour from whichever queue pops it and emits it as a framed pixel stream.
module pixel_combinator #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int NUM_LANES  = 4,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  output logic [DATA_WIDTH-1:0]         xpixel_check,
  output logic [DATA_WIDTH-1:0]         ypixel_check,
  input  logic [NUM_LANES-1:0]          lane_ack_i,
  input  logic [NUM_LANES*RBG_SIZE-1:0] lane_colour_i,
  pixel_combinator_if.master            pix,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          err_o
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  // Queues flag empty slots with all-ones, so the idle x value must be a legal miss.
  localparam logic [DATA_WIDTH-1:0] X_PARK = DATA_WIDTH'(IMG_W);
  localparam logic [XW-1:0]         X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]         Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, SEEK, OUT, DONE} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d, x_nxt;
  logic [YW-1:0]         y_q, y_d, y_nxt;
  logic [DATA_WIDTH-1:0] xchk_q, xchk_d, ychk_q, ychk_d;
  logic                  seek_first_q, seek_first_d;
  logic [RBG_SIZE-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
  logic                  eol_q, eol_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [RBG_SIZE-1:0]   ack_colour;
  logic                  any_ack;
  logic                  multi_ack;

  // Lowest-index lane wins when several queues answer at once.
  always_comb begin
    ack_colour = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (lane_ack_i[k]) ack_colour = lane_colour_i[k*RBG_SIZE +: RBG_SIZE];
    end
  end

  assign any_ack   = |lane_ack_i;
  assign multi_ack = |(lane_ack_i & (lane_ack_i - NUM_LANES'(1)));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    xchk_d       = xchk_q;
    ychk_d       = ychk_q;
    seek_first_d = seek_first_q;
    data_d       = data_q;
    valid_d      = valid_q;
    sof_d        = sof_q;
    eol_d        = eol_q;
    done_d       = 1'b0;
    err_d        = err_q | multi_ack;
    x_nxt        = (x_q == X_LAST) ? '0 : x_q + XW'(1);
    y_nxt        = (x_q == X_LAST) ? y_q + YW'(1) : y_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = SEEK;
          x_d          = '0;
          y_d          = '0;
          xchk_d       = '0;
          ychk_d       = '0;
          seek_first_d = 1'b1;
        end
      end
      SEEK: begin
        // A queue needs one cycle to see a new coordinate, so its first cycle never hits.
        seek_first_d = 1'b0;
        if (any_ack && !seek_first_q) begin
          data_d  = ack_colour;
          valid_d = 1'b1;
          sof_d   = (x_q == '0) && (y_q == '0);
          eol_d   = (x_q == X_LAST);
          xchk_d  = X_PARK;
          ychk_d  = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (any_ack) err_d = 1'b1;
        if (pix.pix_ready_i) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            state_d = DONE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d      = SEEK;
            seek_first_d = 1'b1;
            x_d          = x_nxt;
            y_d          = y_nxt;
            xchk_d       = DATA_WIDTH'(x_nxt);
            ychk_d       = DATA_WIDTH'(y_nxt);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      xchk_q       <= X_PARK;
      ychk_q       <= '0;
      seek_first_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xchk_q       <= xchk_d;
      ychk_q       <= ychk_d;
      seek_first_q <= seek_first_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign xpixel_check    = xchk_q;
  assign ypixel_check    = ychk_q;
  assign pix.pix_data_o  = data_q;
  assign pix.pix_valid_o = valid_q;
  assign pix.sof_o       = sof_q;
  assign pix.eol_o       = eol_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = done_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator: scenario table of whole frames scored against a raster-order
// model of the expected pixel stream, plus hand sequences for reset and protocol errors.
module tb_pixel_combinator;
  localparam int W = 4, H = 2, NL = 2, CW = 24, DW = 32, NPIX = W * H, LW = NL * CW;

  typedef struct {
    int          x;
    int          y;
    logic [CW-1:0] col;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct {
    int ready_mode;   // 0 always, 1 random, 2 stall 5 cycles on (2,0), 3 hold last pixel
    int delay_mode;   // 0 ack one cycle after match, 1 random 1..4 cycles
    int long_pix;     // pixel index whose ack is delayed 20 cycles, -1 none
    int dual_pix;     // pixel index answered by both lanes, -1 none
    bit spur;         // junk ack in the first cycle a coordinate is shown
    bit rand_col;
    bit exp_err;
  } scen_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic [DW-1:0] xchk, ychk;
  logic [NL-1:0] ack = '0;
  logic [LW-1:0] lcol = '0;
  logic busy, fdone, err;
  pixel_combinator_if #(.RBG_SIZE(CW)) pif();

  logic [31:0] d_xchk, d_ychk;
  logic d_busy, d_fdone, d_err;
  pixel_combinator_if #(.RBG_SIZE(24)) pif_d();
  assign pif_d.pix_ready_i = 1'b1;

  always #5 clk = ~clk;

  pixel_combinator #(.DATA_WIDTH(DW), .RBG_SIZE(CW), .NUM_LANES(NL), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .xpixel_check(xchk), .ypixel_check(ychk),
    .lane_ack_i(ack), .lane_colour_i(lcol),
    .pix(pif),
    .busy_o(busy), .frame_done_o(fdone), .err_o(err)
  );

  pixel_combinator dut_def (
    .clk(clk), .reset(reset), .start_i(1'b0),
    .xpixel_check(d_xchk), .ypixel_check(d_ychk),
    .lane_ack_i(4'b0), .lane_colour_i(96'b0),
    .pix(pif_d),
    .busy_o(d_busy), .frame_done_o(d_fdone), .err_o(d_err)
  );

  int vectors = 0, miscompares = 0;
  pix_t exp_q[$];
  logic [CW-1:0] col_tab [NPIX];
  int ready_mode = 0, delay_mode = 0, long_pix = -1, dual_pix = -1;
  bit spur = 1'b0;
  int last_x = -1, last_y = -1, seen = 0, cur_delay = 1, rr = 0, stall_cnt = 0;
  int n_acc = 0, n_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Expected stream: every pixel of the frame once, in raster order.
  task automatic setup_frame(input scen_t s);
    exp_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_t p;
        p.x   = x;
        p.y   = y;
        p.col = s.rand_col ? CW'($urandom) : CW'(x + 16 * y);
        if (y * W + x == s.dual_pix) p.col = 24'hAA;
        p.sof = (x == 0 && y == 0);
        p.eol = (x == W - 1);
        col_tab[y * W + x] = p.col;
        exp_q.push_back(p);
      end
    end
    ready_mode = s.ready_mode;
    delay_mode = s.delay_mode;
    long_pix   = s.long_pix;
    dual_pix   = s.dual_pix;
    spur       = s.spur;
    last_x = -1; last_y = -1; seen = 0; stall_cnt = 0;
    n_acc = 0; n_done = 0;
  endtask

  // Next-cycle inputs: sink readiness and the queue responders.
  task automatic drive();
    int xi, yi, pi;
    ack  = '0;
    lcol = LW'({$urandom, $urandom});
    case (ready_mode)
      0: pif.pix_ready_i = 1'b1;
      1: pif.pix_ready_i = ($urandom_range(0, 3) != 0);
      2: begin
        if (pif.pix_valid_o && exp_q.size() > 0 && exp_q[0].x == 2 && exp_q[0].y == 0 && stall_cnt < 5) begin
          pif.pix_ready_i = 1'b0;
          stall_cnt++;
        end else pif.pix_ready_i = 1'b1;
      end
      default: pif.pix_ready_i = !(pif.pix_valid_o && exp_q.size() == 1);
    endcase
    if (xchk < W && ychk < H) begin
      xi = int'(xchk);
      yi = int'(ychk);
      pi = yi * W + xi;
      if (xi == last_x && yi == last_y) seen++;
      else begin
        seen = 1; last_x = xi; last_y = yi;
        cur_delay = (delay_mode == 1) ? int'($urandom_range(1, 4)) : ((pi == long_pix) ? 20 : 1);
      end
      if (seen == 1 && spur) begin
        ack[0] = 1'b1;
        lcol[0 +: CW] = col_tab[pi] ^ 24'h5A5A5A;
      end
      if (seen == cur_delay + 1) begin
        if (pi == dual_pix) begin
          ack = '1;
          lcol[0 +: CW]  = col_tab[pi];
          lcol[CW +: CW] = 24'hBB;
        end else begin
          ack[rr] = 1'b1;
          lcol[rr * CW +: CW] = col_tab[pi];
          rr = (rr + 1) % NL;
        end
      end
    end
  endtask

  // Score the cycle before the edge, then advance one clock and drive.
  task automatic cycle();
    if (pif.pix_valid_o) begin
      if (exp_q.size() == 0) fail_now("extra_pixel");
      else begin
        check("pix_data", pif.pix_data_o, exp_q[0].col);
        check("sof", pif.sof_o, exp_q[0].sof);
        check("eol", pif.eol_o, exp_q[0].eol);
        check("park_x_in_out", xchk, W);
        if (pif.pix_ready_i) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end else if (xchk != W) begin
      if (exp_q.size() == 0) fail_now("coord_after_last_pixel");
      else begin
        check("seek_x", xchk, exp_q[0].x);
        check("seek_y", ychk, exp_q[0].y);
      end
    end
    if (fdone) n_done++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_frame(input scen_t s);
    int budget;
    setup_frame(s);
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    check("busy_after_start", busy, 1);
    budget = 0;
    while (n_done == 0 && budget < 400) begin
      cycle();
      budget++;
    end
    if (n_done == 0) fail_now("frame_timeout");
    check("pixels_accepted", n_acc, NPIX);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
    check("err_state", err, s.exp_err);
    cycle();
    cycle();
    check("frame_done_once", n_done, 1);
  endtask

  initial begin
    scen_t tbl[7];
    scen_t plain, hold_last, rnd;
    int budget;
    tbl[0] = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{0, 0,  4, -1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, 1, -1, -1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{0, 0, -1, -1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{0, 0, -1,  1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1, 1, -1, -1, 1'b0, 1'b1, 1'b1};
    plain     = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    hold_last = '{3, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    rnd       = '{1, 1, -1, -1, 1'b0, 1'b1, 1'b0};
    pif.pix_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_park_x", xchk, W);
      check("idle_park_x_default", d_xchk, 640);
      check("idle_busy", busy, 0);
    end
    check("idle_y_default", d_ychk, 0);
    check("idle_valid_default", pif_d.pix_valid_o, 0);
    check("idle_flags_default", {d_busy, d_fdone, d_err, pif_d.sof_o, pif_d.eol_o}, 0);
    check("idle_valid", pif.pix_valid_o, 0);
    check("idle_data", pif.pix_data_o, 0);
    check("idle_flags", {pif.sof_o, pif.eol_o, fdone, err}, 0);

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Reset clears the sticky error; an ack while a pixel is held sets it again.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("err_cleared_by_reset", err, 0);
    setup_frame(hold_last);
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    budget = 0;
    while (!(pif.pix_valid_o && exp_q.size() == 1) && budget < 200) begin
      cycle();
      budget++;
    end
    if (budget >= 200) fail_now("reach_last_pixel");
    ack[1] = 1'b1;
    lcol[CW +: CW] = 24'h123456;
    cycle();
    check("err_ack_in_out", err, 1);
    check("last_pixel_held", pif.pix_valid_o, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_valid", pif.pix_valid_o, 0);
    check("abort_busy", busy, 0);
    check("abort_park_x", xchk, W);
    check("abort_err", err, 0);
    check("abort_sof", pif.sof_o, 0);
    run_frame(plain);

    for (int i = 0; i < 3; i++) run_frame(rnd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pixel_combinator.md
Name: pixel_combinator

Overview:
- Downstream stage of the per-engine result queues. Walks the frame in raster order and broadcasts the next expected coordinate on xpixel_check/ypixel_check to all queues.
- Captures the colour from whichever queue pops that coordinate.
- Emits the result as a valid/ready pixel stream with start-of-frame and end-of-line markers for the video output.

Parameters:
- DATA_WIDTH, 32, width of coordinate buses (matches queue ports)
- RBG_SIZE, 24, colour width
- NUM_LANES, 4, number of engine queues feeding this block
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; begin a frame (honoured in IDLE only)
- xpixel_check  out  DATA_WIDTH  expected x, broadcast to all queues
- ypixel_check  out  DATA_WIDTH  expected y, broadcast to all queues
- lane_ack_i  in  NUM_LANES  per-lane pulse: that queue's colour_o is valid this cycle, 1 cycle after its match
- lane_colour_i  in  NUM_LANES*RBG_SIZE  lane k colour in bits [k*RBG_SIZE +: RBG_SIZE]
- pix_data_o  out  RBG_SIZE  output colour
- pix_valid_o  out  1  output pixel valid
- pix_ready_i  in  1  sink accepts pixel when valid&ready
- sof_o  out  1  qualifies pixel (0,0)
- eol_o  out  1  qualifies pixel x=IMG_W-1
- busy_o  out  1  frame in progress (state != IDLE)
- frame_done_o  out  1  one-cycle pulse after last pixel accepted
- err_o  out  1  sticky; set when >1 lane_ack_i bit is high in one cycle

Behaviour:
- Clocking and reset: single clock; reset synchronous, active-high, wins over all other inputs.
- Reset state:
  - state IDLE
  - internal x=0, y=0
  - xpixel_check=IMG_W (park value), ypixel_check=0
  - pix_valid_o=0, pix_data_o=0, sof_o=0, eol_o=0, busy_o=0, frame_done_o=0, err_o=0
- Reset mid-frame: aborts immediately, same values as above; any pixel in OUT is dropped.
- Park value: xpixel_check=IMG_W, never all-ones. Queues mark empty slots with all-ones, so driving all-ones would pop garbage.
- States:
  - IDLE: coords parked. start_i -> SEEK with x=0, y=0.
  - SEEK:
    - Drive xpixel_check=x, ypixel_check=y.
    - If any lane_ack_i bit is high: capture that lane's colour into pix_data_o, set pix_valid_o=1, sof_o=(x==0&&y==0), eol_o=(x==IMG_W-1). Park coords in the same edge; go to OUT.
    - Otherwise stay; no timeout.
    - Holding coords during the ack cycle is safe: the queue front has already advanced, so no double pop.
  - OUT:
    - Hold pix_data_o, sof_o and eol_o stable while pix_valid_o=1 and pix_ready_i=0.
    - On valid&ready, advance the coordinate:
      - if x<IMG_W-1: x+1
      - else x=0, y+1
      - if (IMG_W-1, IMG_H-1) was accepted -> DONE
      - else -> SEEK with the new coordinate, pix_valid_o=0
  - DONE: one cycle; frame_done_o=1, x=y=0, coords parked -> IDLE.
- Latency: best case 3 cycles per pixel:
  - SEEK cycle N (coord presented)
  - ack at N+1
  - OUT at N+2 with ready=1 -> SEEK at N+3
- No acceptance in SEEK's first cycle: an ack arriving in the first SEEK cycle for a new coordinate is ignored, because no queue can have matched yet. Counted per SEEK entry.
- Multiple acks in one cycle: take the lowest lane index, set err_o (sticky until reset).
- Acks outside SEEK are ignored; in OUT they also set err_o.
- start_i outside IDLE is ignored.
- Arithmetic: x, y internal counters are $clog2(IMG_W), $clog2(IMG_H) bits, zero-extended to DATA_WIDTH on the check ports.

Test Plan:
- Reset, then IDLE for 10 cycles -> xpixel_check=640, all outputs 0, busy_o=0.
- IMG_W=4, IMG_H=2, NUM_LANES=2, ready=1; lanes ack alternately one cycle after each matching coord, colour=x+16*y:
  - -> 8 pixels 0x00,01,02,03,10,11,12,13
  - sof_o only on the first pixel; eol_o on the 4th and 8th
  - frame_done_o pulses once; busy_o falls.
- Same frame with pix_ready_i low for 5 cycles on pixel (2,0) -> pix_data_o=0x02 held stable, coords parked at 4, no acks consumed.
- Lanes 0 and 1 both ack for coord (1,0) with colours 0xAA and 0xBB -> output 0xBB is not used, 0xAA emitted, err_o=1 and stays 1 until reset.
- Assert reset while in OUT at pixel (3,1) -> next cycle pix_valid_o=0, state IDLE; a new start_i restarts at (0,0) with sof_o=1.
- Lane ack delayed 20 cycles for (0,1) -> block remains in SEEK driving (0,1); no output until the ack, then the correct colour is emitted.
